// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256/224 constants, types, FSM states and round helper functions.
package sha256_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, UPDATE} state_t;
  typedef logic [0:7][31:0] words8_t;
  typedef logic [0:15][31:0] words16_t;
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam words8_t IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam words8_t IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                               32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction
  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction
  function automatic logic [31:0] sml_sig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sml_sig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] e, f, g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] a, b, c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction
endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round.
//   i_st  working state a..h (a in word 0)
//   i_w   schedule word W[t]
//   i_k   round constant K[t]
//   o_st  working state after the round
module sha256_round
  import sha256_pkg::*;
(
  input  words8_t     i_st,
  input  logic [31:0] i_w,
  input  logic [31:0] i_k,
  output words8_t     o_st
);
  logic [31:0] w_t1, w_t2;
  assign w_t1 = i_st[7] + big_sig1(i_st[4]) + ch(i_st[4], i_st[5], i_st[6]) + i_k + i_w;
  assign w_t2 = big_sig0(i_st[0]) + maj(i_st[0], i_st[1], i_st[2]);
  assign o_st = {w_t1 + w_t2, i_st[0], i_st[1], i_st[2], i_st[3] + w_t1, i_st[4], i_st[5], i_st[6]};
endmodule

// File: rtl/sha256_stream_core.sv
// sha256_stream_core: streaming multi-block SHA-256 compression core, UNROLL rounds per clock.
//   usr_clk, usr_reset_n  clock, asynchronous active-low reset
//   i_valid/o_ready       block handshake; i_msg padded 512-bit block, word 0 in MSBs
//   i_first, i_last       block starts (chain from IV) / ends (emit digest) a message
//   i_mode224             SHA-224 select, only when SHA_MODE224_EN is defined
//   o_valid, o_hash       one-cycle digest pulse and held digest, H0 in MSB word
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int MSG_SIZ   = 512,
  parameter int MSG_BLK   = 32,
  parameter int HASH_SIZE = 256,
  parameter int UNROLL    = 1
) (
  input  logic                 usr_clk,
  input  logic                 usr_reset_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [MSG_SIZ-1:0]   i_msg,
  input  logic                 i_first,
  input  logic                 i_last,
`ifdef SHA_MODE224_EN
  input  logic                 i_mode224,
`endif
  output logic                 o_valid,
  output logic [HASH_SIZE-1:0] o_hash
);
  if (MSG_SIZ != 512 || MSG_BLK != 32 || HASH_SIZE != 256 || !(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_param
    $error("sha256_stream_core: unsupported parameter set");
  end
  state_t      r_state;
  logic [5:0]  r_cnt;
  words16_t    r_w, w_w_nxt;
  words8_t     r_st, r_h, w_c, w_h_nxt;
  logic        r_last, r_mode, r_fresh, w_mode, w_new;
  logic [31:0] w_x [16+UNROLL];
  logic [255:0] w_dig;
`ifdef SHA_MODE224_EN
  assign w_mode = i_mode224;
`else
  assign w_mode = 1'b0;
`endif
  // A block restarts from an IV when it opens a message or when H still holds its reset value;
  // the mode is re-sampled in both cases so a reset-chained block honours SHA-224.
  assign w_new = i_first || r_fresh;
  assign w_c   = w_new ? (w_mode ? IV224 : IV256) : r_h;
  assign w_dig = r_mode ? {w_h_nxt[0:6], 32'h0} : w_h_nxt;
  // Schedule window extended by the UNROLL words consumed this clock; later words may
  // depend on words generated earlier in the same clock.
  always_comb begin
    for (int i = 0; i < 16; i++) w_x[i] = r_w[i];
    for (int i = 0; i < UNROLL; i++) w_x[16+i] = sml_sig1(w_x[14+i]) + w_x[9+i] + sml_sig0(w_x[1+i]) + w_x[i];
    for (int i = 0; i < 16; i++) w_w_nxt[i] = w_x[i+UNROLL];
    for (int i = 0; i < 8; i++) w_h_nxt[i] = r_h[i] + r_st[i];
  end
  for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
    words8_t w_in, w_out;
    if (i == 0) begin : g_head
      assign w_in = r_st;
    end else begin : g_tail
      assign w_in = g_rnd[i-1].w_out;
    end
    sha256_round u_round (.i_st(w_in), .i_w(w_x[i]), .i_k(K[r_cnt + 6'(i)]), .o_st(w_out));
  end
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_w     <= '0;
      r_st    <= '0;
      r_h     <= IV256;
      r_last  <= 1'b0;
      r_mode  <= 1'b0;
      r_fresh <= 1'b1;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_hash  <= '0;
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        IDLE: if (i_valid) begin
          r_w     <= words16_t'(i_msg);
          r_st    <= w_c;
          r_h     <= w_c;
          r_cnt   <= '0;
          r_last  <= i_last;
          r_mode  <= w_new ? w_mode : r_mode;
          r_fresh <= 1'b0;
          o_ready <= 1'b0;
          r_state <= ROUND;
        end
        ROUND: begin
          r_w     <= w_w_nxt;
          r_st    <= g_rnd[UNROLL-1].w_out;
          r_cnt   <= r_cnt + 6'(UNROLL);
          r_state <= (r_cnt == 6'(64 - UNROLL)) ? UPDATE : ROUND;
        end
        UPDATE: begin
          r_h     <= w_h_nxt;
          o_hash  <= r_last ? w_dig : o_hash;
          o_valid <= r_last;
          o_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_stream_core.sv
// tb_sha256_stream_core: scoreboard bench for the streaming SHA-256 core (UNROLL=1 and UNROLL=4).
module tb_sha256_stream_core;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_valid = 1'b0, i_first = 1'b0, i_last = 1'b0, v4 = 1'b0;
  logic [511:0] i_msg = '0;
  logic o_ready, o_valid, rdy4, val4;
  logic [255:0] o_hash, hash4;
`ifdef SHA_MODE224_EN
  logic i_mode = 1'b0;
`endif
  int cyc = 0, checks = 0, failures = 0, acc, acc_prev, acc4;
  logic [255:0] exp_q [$];
  int acc_q [$];
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  sha256_stream_core #(.UNROLL(1)) u_dut (
    .usr_clk(clk), .usr_reset_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_msg(i_msg),
    .i_first(i_first), .i_last(i_last),
`ifdef SHA_MODE224_EN
    .i_mode224(i_mode),
`endif
    .o_valid(o_valid), .o_hash(o_hash));

  sha256_stream_core #(.UNROLL(4)) u_dut4 (
    .usr_clk(clk), .usr_reset_n(rst_n), .i_valid(v4), .o_ready(rdy4), .i_msg(i_msg),
    .i_first(i_first), .i_last(i_last),
`ifdef SHA_MODE224_EN
    .i_mode224(i_mode),
`endif
    .o_valid(val4), .o_hash(hash4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // Scoreboard: each digest pulse must match the oldest outstanding last-block expectation.
  always @(negedge clk) if (rst_n && o_valid) begin
    if (exp_q.size() == 0) chk("spurious_valid", o_valid, 0);
    else begin
      chk("digest", o_hash, exp_q.pop_front());
      chk("latency", cyc - acc_q.pop_front(), 65);
      chk("ready_with_valid", o_ready, 1);
    end
  end

  task automatic send(input logic [511:0] m, input logic f, input logic l, input logic hold,
                      input logic [255:0] exp, output int acc_edge);
    int n = 0;
    @(negedge clk);
    i_valid = 1'b1; i_msg = m; i_first = f; i_last = l;
    while (!o_ready && n < 200) begin @(negedge clk); n++; end
    chk("accept_timeout", n < 200, 1);
    acc_edge = cyc + 1;
    if (l) begin exp_q.push_back(exp); acc_q.push_back(acc_edge); end
    @(posedge clk);
    if (!hold) begin @(negedge clk); i_valid = 1'b0; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !o_ready) && n < 500) begin @(negedge clk); n++; end
    chk("drain_timeout", n < 500, 1);
  endtask

  initial begin
    #22 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", o_ready, 1);
    chk("reset_valid", o_valid, 0);
    chk("reset_hash", o_hash, 0);
    send(ABC, 1, 1, 0, D_ABC, acc);
    wait_idle();
    send(B1, 1, 0, 0, 0, acc);
    send(B2, 0, 1, 0, D_TWO, acc);
    wait_idle();
    send(B1, 1, 0, 0, 0, acc);
    wait_idle();
    chk("hash_held_nonlast", o_hash, D_TWO);
    send(ABC, 1, 1, 1, D_ABC, acc_prev);
    for (int k = 0; k < 2; k++) begin
      send(ABC, 1, 1, 1, D_ABC, acc);
      chk("accept_spacing", acc - acc_prev, 66);
      acc_prev = acc;
    end
    @(negedge clk); i_valid = 1'b0;
    wait_idle();
    send(B1, 1, 0, 0, 0, acc);
    repeat (20) @(negedge clk);
    #3 rst_n = 1'b0;
    #4;
    chk("midrst_ready", o_ready, 1);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_hash", o_hash, 0);
    #4 rst_n = 1'b1;
    send(ABC, 0, 1, 0, D_ABC, acc);
    wait_idle();
`ifdef SHA_MODE224_EN
    i_mode = 1'b1;
    send(ABC, 1, 1, 0, 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000, acc);
    wait_idle();
    i_mode = 1'b0;
`endif
    @(negedge clk);
    i_msg = ABC; i_first = 1'b1; i_last = 1'b1; v4 = 1'b1;
    chk("u4_ready", rdy4, 1);
    acc4 = cyc + 1;
    @(posedge clk);
    @(negedge clk); v4 = 1'b0;
    for (int n = 0; n < 60 && !val4; n++) @(negedge clk);
    chk("u4_latency", cyc - acc4, 17);
    chk("u4_digest", hash4, D_ABC);
    @(negedge clk);
    chk("u4_pulse_one_cycle", val4, 0);
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
